// File: rtl/muse_trig_pkg.sv
// Shared types and constants for the test pulse generator.
package muse_trig_pkg;

    localparam int TPG_PW_BITS       = 8;
    localparam int TPG_CNT_BITS      = 16;
    localparam int TPG_DEFAULT_WIDTH = 48;

    localparam logic [TPG_CNT_BITS-1:0] TPG_CNT_ONE = TPG_CNT_BITS'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } tpg_state_e;

    // Timer reload for a phase of len cycles, with a length of 0 treated as 1.
    function automatic logic [TPG_CNT_BITS-1:0] phase_reload(input logic [TPG_CNT_BITS-1:0] len);
        return (len == '0) ? '0 : (len - TPG_CNT_ONE);
    endfunction

endpackage

// File: rtl/tpg_timer.sv
// Loadable down-counter that times both the HIGH and LOW phases of a pulse.
module tpg_timer
    import muse_trig_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [TPG_CNT_BITS-1:0] load_value,
    output logic [TPG_CNT_BITS-1:0] value,
    output logic                    expire
);

    logic [TPG_CNT_BITS-1:0] count_q, count_d;

    // The count saturates at zero so that expire stays high until the next load.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - TPG_CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign value  = count_q;
    assign expire = (count_q == '0);

endmodule

// File: rtl/test_pulse_gen.sv
// Burst generator of registered test pulses for trigger inputs.
// Optional walking one-hot channel pattern is enabled by defining TPG_WALK_EN.
module test_pulse_gen
    import muse_trig_pkg::*;
#(
    parameter int WIDTH = TPG_DEFAULT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    stop,
`ifdef TPG_WALK_EN
    input  logic                    walk,
`endif
    input  logic [WIDTH-1:0]        chan_mask,
    input  logic [TPG_PW_BITS-1:0]  pulse_width,
    input  logic [TPG_CNT_BITS-1:0] gap,
    input  logic [TPG_CNT_BITS-1:0] burst_len,
    output logic [WIDTH-1:0]        Pulse_out,
    output logic                    busy,
    output logic                    done,
    output logic [TPG_CNT_BITS-1:0] pulse_cnt
);

    tpg_state_e              state_q, state_d;
    logic                    pending_q, pending_d;
    logic [WIDTH-1:0]        mask_q, mask_d;
    logic [TPG_PW_BITS-1:0]  width_q, width_d;
    logic [TPG_CNT_BITS-1:0] gap_q, gap_d;
    logic [TPG_CNT_BITS-1:0] len_q, len_d;
    logic [TPG_CNT_BITS-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]        pulse_out_q, pulse_out_d;
    logic                    done_q, done_d;

    logic                    latch_cfg;
    logic                    pulse_end;
    logic [WIDTH-1:0]        pulse_pattern;
    logic                    timer_load;
    logic [TPG_CNT_BITS-1:0] timer_load_value;
    logic [TPG_CNT_BITS-1:0] unused_timer_value;
    logic                    timer_expire;

    tpg_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .load_value (timer_load_value),
        .value      (unused_timer_value),
        .expire     (timer_expire)
    );

    // A start spends one cycle latching configuration before the first HIGH phase.
    always_comb begin
        state_d          = state_q;
        pending_d        = 1'b0;
        pulse_out_d      = '0;
        done_d           = 1'b0;
        latch_cfg        = 1'b0;
        pulse_end        = 1'b0;
        timer_load       = 1'b0;
        timer_load_value = phase_reload(TPG_CNT_BITS'(width_q));

        unique case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    state_d     = ST_HIGH;
                    pulse_out_d = pulse_pattern;
                    timer_load  = 1'b1;
                end else if (start && !stop) begin
                    latch_cfg = 1'b1;
                    pending_d = 1'b1;
                end
            end
            ST_HIGH: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (timer_expire) begin
                    state_d          = ST_LOW;
                    pulse_end        = 1'b1;
                    timer_load       = 1'b1;
                    timer_load_value = phase_reload(gap_q);
                end else begin
                    pulse_out_d = pulse_pattern;
                end
            end
            ST_LOW: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (timer_expire) begin
                    if ((len_q != '0) && (cnt_q == len_q)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = ST_HIGH;
                        pulse_out_d = pulse_pattern;
                        timer_load  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        mask_d  = mask_q;
        width_d = width_q;
        gap_d   = gap_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        if (latch_cfg) begin
            mask_d  = chan_mask;
            width_d = pulse_width;
            gap_d   = gap;
            len_d   = burst_len;
            cnt_d   = '0;
        end else if (pulse_end) begin
            cnt_d = cnt_q + TPG_CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pending_q   <= 1'b0;
            mask_q      <= '0;
            width_q     <= '0;
            gap_q       <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            pulse_out_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            width_q     <= width_d;
            gap_q       <= gap_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            pulse_out_q <= pulse_out_d;
            done_q      <= done_d;
        end
    end

`ifdef TPG_WALK_EN
    logic             walk_q, walk_d;
    logic [WIDTH-1:0] walk_pat_q, walk_pat_d;

    // The one-hot pattern restarts at bit 0 for each burst and advances after every pulse.
    always_comb begin
        walk_d     = walk_q;
        walk_pat_d = walk_pat_q;
        if (latch_cfg) begin
            walk_d     = walk;
            walk_pat_d = WIDTH'(1);
        end else if (pulse_end) begin
            walk_pat_d = {walk_pat_q[WIDTH-2:0], walk_pat_q[WIDTH-1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            walk_q     <= 1'b0;
            walk_pat_q <= '0;
        end else begin
            walk_q     <= walk_d;
            walk_pat_q <= walk_pat_d;
        end
    end

    assign pulse_pattern = walk_q ? (mask_q & walk_pat_q) : mask_q;
`else
    assign pulse_pattern = mask_q;
`endif

    assign Pulse_out = pulse_out_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign pulse_cnt = cnt_q;

endmodule

// File: tb/tb_test_pulse_gen.sv
// Directed self-checking bench for test_pulse_gen; walk checks compile only with TPG_WALK_EN.
module tb_test_pulse_gen;

    localparam int WIDTH = 48;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             stop;
`ifdef TPG_WALK_EN
    logic             walk = 1'b0;
`endif
    logic [WIDTH-1:0] chan_mask;
    logic [7:0]       pulse_width;
    logic [15:0]      gap;
    logic [15:0]      burst_len;
    logic [WIDTH-1:0] Pulse_out;
    logic             busy;
    logic             done;
    logic [15:0]      pulse_cnt;

    int check_count = 0;
    int pass_count  = 0;

    test_pulse_gen #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
`ifdef TPG_WALK_EN
        .walk        (walk),
`endif
        .chan_mask   (chan_mask),
        .pulse_width (pulse_width),
        .gap         (gap),
        .burst_len   (burst_len),
        .Pulse_out   (Pulse_out),
        .busy        (busy),
        .done        (done),
        .pulse_cnt   (pulse_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count = check_count + 1;
        assert (observed === expected) pass_count = pass_count + 1;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [WIDTH-1:0] m, input logic [7:0] w,
                                  input logic [15:0] g, input logic [15:0] n);
        chan_mask   = m;
        pulse_width = w;
        gap         = g;
        burst_len   = n;
        start       = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the bench finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int busy_cycles;
        logic [63:0] exp_pulse;

        rst_n = 1'b1; start = 1'b0; stop = 1'b0;
        chan_mask = '0; pulse_width = '0; gap = '0; burst_len = '0;
        #1 rst_n = 1'b0;
        #2;
        check_output("rst_pulse", 64'(Pulse_out), 64'h0);
        check_output("rst_busy",  64'(busy),      64'h0);
        check_output("rst_done",  64'(done),      64'h0);
        check_output("rst_cnt",   64'(pulse_cnt), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("[TB] single burst width=3 gap=2 len=2 with mid-burst disturbances");
        apply_stimulus(48'h1, 8'd3, 16'd2, 16'd2);
        tick();
        start = 1'b0;
        check_output("t1_c0_busy", 64'(busy), 64'h0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_pulse = (((k >= 1) && (k <= 3)) || ((k >= 6) && (k <= 8))) ? 64'h1 : 64'h0;
            check_output($sformatf("t1_c%0d_pulse", k), 64'(Pulse_out), exp_pulse);
            check_output($sformatf("t1_c%0d_busy", k),  64'(busy), ((k >= 1) && (k <= 10)) ? 64'h1 : 64'h0);
            check_output($sformatf("t1_c%0d_done", k),  64'(done), (k == 11) ? 64'h1 : 64'h0);
            if (k == 4)  check_output("t1_cnt_after_first", 64'(pulse_cnt), 64'd1);
            if (k == 11) check_output("t1_cnt_final", 64'(pulse_cnt), 64'd2);
            if (k == 2) begin
                chan_mask = '1; pulse_width = 8'd9; gap = 16'd7; burst_len = 16'd0;
            end
            if (k == 4) start = 1'b1;
            if (k == 8) start = 1'b0;
        end

        $display("[TB] zero width, zero gap, len=1");
        apply_stimulus(48'h3, 8'd0, 16'd0, 16'd1);
        tick();
        start = 1'b0;
        busy_cycles = 0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (busy) busy_cycles = busy_cycles + 1;
            check_output($sformatf("t2_c%0d_pulse", k), 64'(Pulse_out), (k == 1) ? 64'h3 : 64'h0);
            check_output($sformatf("t2_c%0d_done", k),  64'(done), (k == 3) ? 64'h1 : 64'h0);
        end
        check_output("t2_busy_cycles", 64'(busy_cycles), 64'd2);
        check_output("t2_cnt", 64'(pulse_cnt), 64'd1);

        $display("[TB] start and stop together in idle");
        apply_stimulus(48'hF, 8'd1, 16'd1, 16'd1);
        stop = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_output($sformatf("t3_c%0d_busy", k),  64'(busy), 64'h0);
            check_output($sformatf("t3_c%0d_pulse", k), 64'(Pulse_out), 64'h0);
            check_output($sformatf("t3_c%0d_done", k),  64'(done), 64'h0);
        end
        start = 1'b0;
        stop  = 1'b0;

        $display("[TB] continuous burst aborted by stop");
        apply_stimulus('1, 8'd2, 16'd1, 16'd0);
        tick();
        start = 1'b0;
        for (int k = 1; k <= 49; k++) tick();
        check_output("t4_c49_pulse", 64'(Pulse_out), 64'hFFFF_FFFF_FFFF);
        check_output("t4_c49_cnt",   64'(pulse_cnt), 64'd16);
        tick();
        check_output("t4_c50_busy", 64'(busy), 64'h1);
        check_output("t4_c50_done", 64'(done), 64'h0);
        stop = 1'b1;
        tick();
        check_output("t4_c51_pulse", 64'(Pulse_out), 64'h0);
        check_output("t4_c51_done",  64'(done), 64'h1);
        check_output("t4_c51_busy",  64'(busy), 64'h0);
        check_output("t4_c51_cnt",   64'(pulse_cnt), 64'd16);
        tick();
        check_output("t4_c52_done", 64'(done), 64'h0);
        check_output("t4_c52_cnt",  64'(pulse_cnt), 64'd16);
        tick();
        check_output("t4_c53_done", 64'(done), 64'h0);
        stop = 1'b0;

        $display("[TB] asynchronous reset during a HIGH phase");
        apply_stimulus(48'hA, 8'd2, 16'd1, 16'd5);
        tick();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        check_output("t5_c4_pulse", 64'(Pulse_out), 64'hA);
        check_output("t5_c4_cnt",   64'(pulse_cnt), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_output("t5_rst_pulse", 64'(Pulse_out), 64'h0);
        check_output("t5_rst_busy",  64'(busy), 64'h0);
        check_output("t5_rst_cnt",   64'(pulse_cnt), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_output("t5_post_latch_busy", 64'(busy), 64'h0);
        tick();
        check_output("t5_post_high_busy",  64'(busy), 64'h1);
        check_output("t5_post_high_pulse", 64'(Pulse_out), 64'hA);
        stop = 1'b1;
        tick();
        check_output("t5_post_stop_done", 64'(done), 64'h1);
        stop = 1'b0;
        tick();

`ifdef TPG_WALK_EN
        $display("[TB] walking pattern over mask 0x5");
        walk = 1'b1;
        apply_stimulus(48'h5, 8'd1, 16'd1, 16'd4);
        tick();
        start = 1'b0;
        walk  = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            case (k)
                1:       exp_pulse = 64'h1;
                5:       exp_pulse = 64'h4;
                default: exp_pulse = 64'h0;
            endcase
            check_output($sformatf("t6_c%0d_pulse", k), 64'(Pulse_out), exp_pulse);
        end
        check_output("t6_done", 64'(done), 64'h1);
        check_output("t6_cnt",  64'(pulse_cnt), 64'd4);
`endif

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
